// File: rtl/debug_word_loader_if.sv
// Write port bundle between the word loader and the memory side.
// The master raises wr_valid with addr/data and holds them until wr_ready.
interface debug_word_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/debug_word_loader.sv
// Board word loader: nibbles from SW[3:0] are packed into a word and written out.
// Define DEBOUNCE_LOADER_EN to debounce the raw push-buttons.
module debug_word_loader #(
  parameter int              DATA_W          = 32,
  parameter int              ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int              DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_enter_n,
  input  logic               key_commit_n,
  input  logic               key_clear_n,
  input  logic [3:0]         sw_nibble,
  debug_word_loader_if.master wr,
  output logic [DATA_W-1:0]  entry_word,
  output logic [3:0]         nibble_cnt,
  output logic               busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef DEBOUNCE_LOADER_EN
  localparam int unsigned LIM = DEBOUNCE_CYCLES;
`else
  localparam int unsigned LIM = 0;
`endif
  localparam logic [3:0] NIB = 4'(DATA_W / 4);

  typedef enum logic {ENTRY, WRITE} state_t;

  state_t state, state_nx;

  logic [2:0]    key_n;
  logic [2:0]    sync1, sync2, level, pulse;
  logic [CW-1:0] db_cnt [3];

  logic [DATA_W-1:0] word_nx;
  logic [3:0]        cnt_nx;
  logic [ADDR_W-1:0] addr_nx;

  logic key_ent, key_cmt, key_clr;

  assign key_n   = {key_clear_n, key_commit_n, key_enter_n};
  assign key_ent = pulse[0];
  assign key_cmt = pulse[1];
  assign key_clr = pulse[2];

  // level is the accepted key state; with LIM=0 it simply follows sync2
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      level <= '1;
      pulse <= '0;
      for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      pulse <= '0;
      for (int k = 0; k < 3; k++) begin
        if (sync2[k] != level[k]) begin
          if (db_cnt[k] == CW'(LIM)) begin
            level[k]  <= sync2[k];
            pulse[k]  <= ~sync2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ENTRY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    word_nx  = entry_word;
    cnt_nx   = nibble_cnt;
    addr_nx  = wr.wr_addr;
    unique case (state)
      ENTRY: begin
        unique case (1'b1)
          key_clr: begin
            word_nx = '0;
            cnt_nx  = '0;
          end
          default: begin
            if (key_ent) begin
              word_nx = {entry_word[DATA_W-5:0], sw_nibble};
              cnt_nx  = nibble_cnt + 4'd1;
            end
            if ((key_ent && cnt_nx == NIB) ||
                (key_cmt && cnt_nx != 4'd0))
              state_nx = WRITE;
          end
        endcase
      end
      WRITE: begin
        if (wr.wr_ready) begin
          addr_nx  = wr.wr_addr + ADDR_W'(4);
          word_nx  = '0;
          cnt_nx   = '0;
          state_nx = ENTRY;
        end
      end
      default: state_nx = ENTRY;
    endcase
  end

  always_comb begin
    wr.wr_valid = (state == WRITE);
    busy        = (state == WRITE);
    wr.wr_data  = entry_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_word <= '0;
      nibble_cnt <= '0;
      wr.wr_addr <= BASE_ADDR;
    end else begin
      entry_word <= word_nx;
      nibble_cnt <= cnt_nx;
      wr.wr_addr <= addr_nx;
    end
  end

endmodule

// File: tb/tb_debug_word_loader.sv
// Random and directed key sequences checked against a word-level loader model.
// Writes are captured by a handshake monitor and matched against the model.
module tb_debug_word_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
`ifdef DEBOUNCE_LOADER_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int HOLD = DB + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_enter_n = 1'b1;
  logic       key_commit_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [3:0] sw_nibble = '0;
  logic [31:0] entry_word;
  logic [3:0]  nibble_cnt;
  logic        busy;

  debug_word_loader_if #(.DATA_W(32), .ADDR_W(32)) wr ();

  debug_word_loader #(
    .DATA_W(32),
    .ADDR_W(32),
    .BASE_ADDR(BASE),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_enter_n(key_enter_n),
    .key_commit_n(key_commit_n),
    .key_clear_n(key_clear_n),
    .sw_nibble(sw_nibble),
    .wr(wr),
    .entry_word(entry_word),
    .nibble_cnt(nibble_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_word;
  logic [31:0] m_addr;
  int          m_cnt;
  logic [63:0] obs [$];

  always @(posedge clk)
    if (!rst && wr.wr_valid && wr.wr_ready)
      obs.push_back({wr.wr_addr, wr.wr_data});

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic press(bit en, bit cm, bit cl, logic [3:0] nib);
    @(negedge clk);
    sw_nibble    = nib;
    key_enter_n  = !en;
    key_commit_n = !cm;
    key_clear_n  = !cl;
    repeat (HOLD) @(negedge clk);
    key_enter_n  = 1'b1;
    key_commit_n = 1'b1;
    key_clear_n  = 1'b1;
    repeat (HOLD) @(negedge clk);
  endtask

  // Word-level model of one combined key event; returns 1 if a write is due
  function automatic bit model_apply(bit en, bit cm, bit cl, logic [3:0] nib);
    if (cl) begin
      m_word = '0;
      m_cnt  = 0;
      return 1'b0;
    end
    if (en) begin
      m_word = {m_word[27:0], nib};
      m_cnt++;
    end
    return (en && m_cnt == 8) || (cm && m_cnt > 0);
  endfunction

  task automatic expect_write_done();
    logic [63:0] e;
    check("wr_count", 64'(obs.size()), 64'd1);
    if (obs.size() > 0) begin
      e = obs.pop_front();
      check("wr_addr", e[63:32], m_addr);
      check("wr_data", e[31:0], m_word);
    end
    obs.delete();
    m_addr = m_addr + 32'd4;
    m_word = '0;
    m_cnt  = 0;
  endtask

  task automatic act(bit en, bit cm, bit cl, logic [3:0] nib,
                     bit rdy_pre, int stall);
    bit w;
    wr.wr_ready = rdy_pre;
    press(en, cm, cl, nib);
    w = model_apply(en, cm, cl, nib);
    if (w && rdy_pre) begin
      wr.wr_ready = 1'b0;
      expect_write_done();
    end else if (w) begin
      check("wr_valid", 64'(wr.wr_valid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("hold_addr", wr.wr_addr, m_addr);
      check("hold_data", wr.wr_data, m_word);
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b1, 4'($urandom));
        check("stall_valid", 64'(wr.wr_valid), 64'd1);
        check("stall_addr", wr.wr_addr, m_addr);
        check("stall_data", wr.wr_data, m_word);
        check("stall_cnt", 64'(nibble_cnt), 64'(m_cnt));
      end
      wr.wr_ready = 1'b1;
      @(negedge clk);
      wr.wr_ready = 1'b0;
      check("valid_drop", 64'(wr.wr_valid), 64'd0);
      expect_write_done();
    end else begin
      wr.wr_ready = 1'b0;
      check("no_write", 64'(obs.size()), 64'd0);
      obs.delete();
      check("idle_valid", 64'(wr.wr_valid), 64'd0);
    end
    check("entry_word", entry_word, m_word);
    check("nibble_cnt", 64'(nibble_cnt), 64'(m_cnt));
    check("addr", wr.wr_addr, m_addr);
  endtask

  initial begin
    bit w;
    wr.wr_ready = 1'b0;
    m_word = '0;
    m_addr = BASE;
    m_cnt  = 0;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(wr.wr_valid), 64'd0);
    check("rst_addr", wr.wr_addr, BASE);
    check("rst_data", wr.wr_data, 32'd0);
    check("rst_word", entry_word, 32'd0);
    check("rst_cnt", 64'(nibble_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    for (int i = 1; i <= 8; i++) act(1, 0, 0, 4'(i), 0, 0);
    act(1, 0, 0, 4'hA, 0, 0);
    act(1, 0, 0, 4'hB, 0, 0);
    act(0, 1, 0, 4'h0, 0, 0);
    act(0, 1, 0, 4'h0, 0, 0);
    act(1, 0, 0, 4'h3, 0, 0);
    act(1, 0, 0, 4'h4, 0, 0);
    act(1, 0, 0, 4'h5, 0, 0);
    act(0, 0, 1, 4'h0, 0, 0);
    act(1, 0, 0, 4'hF, 0, 0);
    act(0, 1, 0, 4'h0, 0, 0);
    act(1, 0, 0, 4'h7, 0, 0);
    act(1, 0, 1, 4'h9, 0, 0);
    act(1, 0, 0, 4'hC, 0, 0);
    act(0, 1, 0, 4'h0, 0, 10);
    act(1, 1, 0, 4'hD, 0, 0);
    act(1, 0, 0, 4'h2, 1, 0);
    act(0, 1, 0, 4'h0, 1, 0);

`ifdef DEBOUNCE_LOADER_EN
    @(negedge clk);
    sw_nibble   = 4'h6;
    key_enter_n = 1'b0;
    repeat (5) @(negedge clk);
    key_enter_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    check("glitch_cnt", 64'(nibble_cnt), 64'(m_cnt));
    check("glitch_word", entry_word, m_word);
`endif

    press(1, 0, 0, 4'h5);
    w = model_apply(1, 0, 0, 4'h5);
    press(0, 1, 0, 4'h0);
    w = model_apply(0, 1, 0, 4'h0);
    check("pre_rst_valid", 64'(wr.wr_valid), 64'(w));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 64'(wr.wr_valid), 64'd0);
    check("mid_rst_addr", wr.wr_addr, BASE);
    check("mid_rst_word", entry_word, 32'd0);
    check("mid_rst_cnt", 64'(nibble_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_nowr", 64'(obs.size()), 64'd0);
    obs.delete();
    m_addr = BASE;
    m_word = '0;
    m_cnt  = 0;

    for (int i = 0; i < 50; i++) begin
      act($urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 2,
          $urandom_range(0, 19) == 0,
          4'($urandom),
          $urandom_range(0, 3) == 0,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
